// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction prefetch unit.
// Holds the fetch FSM state encoding, the default reset fetch address,
// the default queue entry field widths and a small response helper.
package ifu_pkg;

    // Fetch FSM: IDLE decides whether a slot is free, REQ drives the read
    // address channel, WAIT collects the single outstanding response.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } fetch_state_e;

    // Default first fetch address after reset.
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    // Default queue entry field widths: {fault, instruction, pc}.
    localparam int IFU_ADDR_W  = 32;
    localparam int IFU_DATA_W  = 32;
    localparam int IFU_FAULT_W = 1;

    // Any nonzero read response marks the fetched word as faulted.
    function automatic logic resp_is_fault(input logic [1:0] resp);
        return (resp != 2'b00);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Instruction queue for the prefetch unit: a DEPTH-entry circular buffer.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             empties the queue; wins over push/pop in the same cycle
//   push, din         write one entry (accepted when not full, or when a pop
//                     frees a slot in the same cycle)
//   pop               remove the head entry (ignored when empty)
//   dout              head entry
//   count             number of valid entries (0..DEPTH)
//   empty, full       occupancy flags
module ifu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests: a pop needs data, a push needs room (a same-cycle pop
    // makes room, so push+pop at full keeps the count unchanged).
    always_comb begin
        do_pop_s  = pop & (count_r != {CNT_W{1'b0}});
        do_push_s = push & ((count_r != CNT_MAX) | do_pop_s);
    end

    // Storage, pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == {CNT_W{1'b0}});
    assign full  = (count_r == CNT_MAX);

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: sequential fetch over an AXI-like read channel
// (one read outstanding) into a small instruction queue, with redirect.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   redirect_valid, redirect_pc     one-cycle flush and refetch request
//   araddr, arvalid, arready        read address channel
//   rdata, rresp, rvalid, rready    read data channel
//   out_valid, out_ready            head-of-queue handshake
//   out_pc, out_inst, out_fault     head entry contents (zero when empty)
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = IFU_ADDR_W,
    parameter int                    DATA_WIDTH = IFU_DATA_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(IFU_RESET_PC),
    parameter int                    DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic                  out_fault
);

    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH + IFU_FAULT_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(32'd4);

    fetch_state_e          state_r;
    fetch_state_e          state_next_s;
    logic [ADDR_WIDTH-1:0] fetch_pc_r;
    logic [ADDR_WIDTH-1:0] req_pc_r;
    logic                  drop_r;
    logic [ADDR_WIDTH-1:0] redirect_al_s;
    logic                  ar_hs_s;
    logic                  resp_done_s;
    logic [CNT_W:0]        occ_next_s;
    logic                  can_issue_s;
    logic                  push_s;
    logic                  pop_s;
    logic [ENTRY_W-1:0]    push_data_s;
    logic [ENTRY_W-1:0]    head_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic                  unused_redirect_lsb_s;

    // Redirect targets are word aligned; the low address bits are ignored.
    assign redirect_al_s         = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsb_s = &{1'b0, redirect_pc[1:0]};

    assign ar_hs_s     = (state_r == ST_REQ) & arready;
    assign resp_done_s = (state_r == ST_WAIT) & rvalid;

    // A new request may start only if the queue can absorb it. In IDLE
    // nothing is in flight, so occupancy after issue is count + 1.
    assign occ_next_s  = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, 1'b1};
    assign can_issue_s = (occ_next_s <= (CNT_W + 1)'(DEPTH));

    // Fetch FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Fetch FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (can_issue_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (arready) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (rvalid) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Fetch FSM outputs, decoded from the state register only.
    always_comb begin
        arvalid = 1'b0;
        rready  = 1'b0;
        case (state_r)
            ST_REQ:  arvalid = 1'b1;
            ST_WAIT: rready  = 1'b1;
            default: begin
                arvalid = 1'b0;
                rready  = 1'b0;
            end
        endcase
    end

    // The request address is latched when leaving IDLE so that a redirect
    // during REQ cannot disturb an address the slave has not yet accepted;
    // it doubles as the PC recorded with the returned word.
    assign araddr = req_pc_r;

    // Fetch PC, request PC and the drop flag for a response made stale by
    // a redirect. While drop is set, fetch_pc already holds the redirect
    // target, so the stale handshake must not advance it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= RESET_PC;
            drop_r     <= 1'b0;
        end else begin
            if (redirect_valid) begin
                fetch_pc_r <= redirect_al_s;
            end else if (ar_hs_s && !drop_r) begin
                fetch_pc_r <= fetch_pc_r + PC_STEP;
            end

            if ((state_r == ST_IDLE) && (state_next_s == ST_REQ)) begin
                req_pc_r <= redirect_valid ? redirect_al_s : fetch_pc_r;
            end

            // A response arriving with the redirect is discarded directly,
            // so only an unanswered in-flight read needs the flag.
            if (resp_done_s) begin
                drop_r <= 1'b0;
            end else if (redirect_valid &&
                         ((state_r == ST_REQ) || (state_r == ST_WAIT))) begin
                drop_r <= 1'b1;
            end
        end
    end

    assign push_data_s = {resp_is_fault(rresp), rdata, req_pc_r};
    assign pop_s       = ~fifo_empty_s & out_ready;
    assign push_s      = resp_done_s & ~drop_r & ~redirect_valid &
                         (~fifo_full_s | pop_s);

    ifu_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push_s),
        .din   (push_data_s),
        .pop   (pop_s),
        .dout  (head_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    // Head entry presentation; fields read as zero while the queue is empty.
    always_comb begin
        out_valid = ~fifo_empty_s;
        if (fifo_empty_s) begin
            out_pc    = {ADDR_WIDTH{1'b0}};
            out_inst  = {DATA_WIDTH{1'b0}};
            out_fault = 1'b0;
        end else begin
            out_pc    = head_s[ADDR_WIDTH-1:0];
            out_inst  = head_s[ADDR_WIDTH +: DATA_WIDTH];
            out_fault = head_s[ENTRY_W-1];
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
module tb_ifu_prefetch;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;

    int total;
    int bad;

    ifu_prefetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_fault      (out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle-table record: inputs for the cycle and expected outputs.
    typedef struct {
        logic        ar;
        logic        r;
        logic [31:0] d;
        logic [1:0]  resp;
        logic        ordy;
        logic        e_arv;
        logic [31:0] e_addr;
        logic        e_rr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_f;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        arready        = 1'b0;
        rvalid         = 1'b0;
        rdata          = 32'h0;
        rresp          = 2'b00;
        out_ready      = 1'b0;
        #1;
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_fault", {31'd0, out_fault}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for a read request; a timeout counts as a failure.
    task automatic wait_ar(input string name);
        int n = 0;
        while (arvalid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (arvalid !== 1'b1) begin
            bad++;
            $display("FAIL %s: no read request after %0d cycles, want arvalid=1", name, n);
        end
    endtask

    // Accept one read request at the expected address (slave side).
    task automatic issue(input string name, input logic [31:0] exp_addr);
        wait_ar(name);
        chk({name, "_araddr"}, araddr, exp_addr);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk({name, "_rready"}, {31'd0, rready}, 32'd1);
    endtask

    // Full zero-wait read: accept the request, then answer one cycle later.
    task automatic do_fetch(input string name, input logic [31:0] exp_addr,
                            input logic [31:0] data, input logic [1:0] resp);
        issue(name, exp_addr);
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        tick();
        rvalid = 1'b0;
        rresp  = 2'b00;
    endtask

    initial begin
        int seen;
        total = 0;
        bad   = 0;

        //            ar    r     d             resp   ordy  e_arv e_addr        e_rr  e_ov  e_pc          e_inst        e_f
        vecs[0] = '{1'b1, 1'b0, 32'h0,        2'b00, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h0,        2'b00, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0013, 2'b00, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h0,        2'b00, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h0,        2'b00, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0013, 2'b10, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[6] = '{1'b1, 1'b0, 32'h0,        2'b00, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0004, 32'h0000_0013, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 32'h0,        2'b00, 1'b1, 1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[8] = '{1'b1, 1'b1, 32'h0000_0013, 2'b00, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[9] = '{1'b1, 1'b0, 32'h0,        2'b00, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0008, 32'h0000_0013, 1'b0};

        // Zero-wait stream after reset, fault on the second fetch.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("vec%0d_arvalid", i), {31'd0, arvalid}, {31'd0, vecs[i].e_arv});
            if (vecs[i].e_arv) chk($sformatf("vec%0d_araddr", i), araddr, vecs[i].e_addr);
            chk($sformatf("vec%0d_rready", i), {31'd0, rready}, {31'd0, vecs[i].e_rr});
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].e_pc);
                chk($sformatf("vec%0d_out_inst", i), out_inst, vecs[i].e_inst);
                chk($sformatf("vec%0d_out_fault", i), {31'd0, out_fault}, {31'd0, vecs[i].e_f});
            end
            arready   = vecs[i].ar;
            rvalid    = vecs[i].r;
            rdata     = vecs[i].d;
            rresp     = vecs[i].resp;
            out_ready = vecs[i].ordy;
            tick();
        end
        arready = 1'b0;
        rvalid  = 1'b0;
        rresp   = 2'b00;

        // Backpressure: queue fills to DEPTH, then one pop allows one fetch.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_fetch($sformatf("fill%0d", i), 32'h8000_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'b00);
        end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (arvalid === 1'b1) seen++;
            tick();
        end
        chk("full_no_ar", 32'(seen), 32'd0);
        chk("full_head_pc", out_pc, 32'h8000_0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        do_fetch("refill", 32'h8000_0010, 32'hA000_0004, 2'b00);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (arvalid === 1'b1) seen++;
            tick();
        end
        chk("refull_no_ar", 32'(seen), 32'd0);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("drain%0d_pc", i), out_pc, 32'h8000_0000 + 32'(4 * i));
            chk($sformatf("drain%0d_inst", i), out_inst, 32'hA000_0000 + 32'(i));
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;

        // Redirect while WAIT: queued and in-flight data discarded.
        do_reset();
        do_fetch("w_first", 32'h8000_0000, 32'hB000_0000, 2'b00);
        issue("w_second", 32'h8000_0004);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        chk("w_flushed", {31'd0, out_valid}, 32'd0);
        rvalid = 1'b1;
        rdata  = 32'hB000_0001;
        tick();
        rvalid = 1'b0;
        chk("w_dropped", {31'd0, out_valid}, 32'd0);
        do_fetch("w_target", 32'h8000_0100, 32'hB000_0002, 2'b00);
        chk("w_target_valid", {31'd0, out_valid}, 32'd1);
        chk("w_target_pc", out_pc, 32'h8000_0100);
        chk("w_target_inst", out_inst, 32'hB000_0002);

        // Stalled AR with a redirect in between, then redirect with same-cycle rvalid.
        do_reset();
        out_ready = 1'b1;
        wait_ar("stall_ar");
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_arvalid", k), {31'd0, arvalid}, 32'd1);
            chk($sformatf("stall%0d_araddr", k), araddr, 32'h8000_0000);
            redirect_valid = (k == 2);
            redirect_pc    = 32'h8000_0200;
            tick();
            redirect_valid = 1'b0;
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'hC000_0000;
        tick();
        rvalid = 1'b0;
        chk("stall_dropped", {31'd0, out_valid}, 32'd0);
        do_fetch("stall_target", 32'h8000_0200, 32'hC000_0001, 2'b00);
        chk("stall_target_pc", out_pc, 32'h8000_0200);
        chk("stall_target_inst", out_inst, 32'hC000_0001);
        tick();
        issue("same_cyc", 32'h8000_0204);
        rvalid         = 1'b1;
        rdata          = 32'hC000_0002;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        tick();
        rvalid         = 1'b0;
        redirect_valid = 1'b0;
        chk("same_cyc_dropped", {31'd0, out_valid}, 32'd0);
        do_fetch("same_cyc_target", 32'h8000_0300, 32'hC000_0003, 2'b00);
        chk("same_cyc_kept", {31'd0, out_valid}, 32'd1);
        chk("same_cyc_pc", out_pc, 32'h8000_0300);
        out_ready = 1'b0;

        // Reset during WAIT abandons the read; then redirect and address wrap.
        issue("abandon", 32'h8000_0304);
        do_reset();
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        tick();
        rvalid = 1'b0;
        chk("abandon_no_entry", {31'd0, out_valid}, 32'd0);
        do_fetch("post_rst", 32'h8000_0000, 32'hD000_0000, 2'b00);
        chk("post_rst_pc", out_pc, 32'h8000_0000);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_flushed", {31'd0, out_valid}, 32'd0);
        do_fetch("wrap_a", 32'hFFFF_FFFC, 32'hD000_0001, 2'b00);
        do_fetch("wrap_b", 32'h0000_0000, 32'hD000_0002, 2'b01);
        chk("wrap_head_pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap_head_fault", {31'd0, out_fault}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("wrap_next_pc", out_pc, 32'h0000_0000);
        chk("wrap_next_inst", out_inst, 32'hD000_0002);
        chk("wrap_next_fault", {31'd0, out_fault}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 Parameter ADDR_WIDTH, default 32, fetch address and PC width.
REQ-003 Parameter DATA_WIDTH, default 32, instruction width.
REQ-004 Parameter DEPTH, default 4, instruction queue entries; power of two, >= 2.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 redirect_valid  input  1  single-cycle request to flush and refetch.
REQ-008 redirect_pc  input  ADDR_WIDTH  new fetch address.
REQ-009 araddr  output  ADDR_WIDTH  read request address.
REQ-010 arvalid  output  1  read request valid.
REQ-011 arready  input  1  read request accepted.
REQ-012 rdata  input  DATA_WIDTH  read data.
REQ-013 rresp  input  2  read response code; nonzero means error.
REQ-014 rvalid  input  1  read data valid.
REQ-015 rready  output  1  module ready for read data.
REQ-016 out_valid  output  1  queue head holds a valid instruction.
REQ-017 out_ready  input  1  downstream consumes the head.
REQ-018 out_pc  output  ADDR_WIDTH  PC of the head entry.
REQ-019 out_inst  output  DATA_WIDTH  instruction of the head entry.
REQ-020 out_fault  output  1  head entry returned rresp != 0.

Function
REQ-021 Fetch FSM states: IDLE, REQ, WAIT; one read outstanding at most.
REQ-022 IDLE -> REQ when (queue count + 1) <= DEPTH, counting an in-flight slot as occupied; otherwise stay in IDLE.
REQ-023 REQ: arvalid=1 and araddr=fetch_pc; REQ -> WAIT on arvalid&&arready; araddr/arvalid stay stable until accepted.
REQ-024 WAIT: rready=1; WAIT -> IDLE on rvalid; rready=0 in IDLE/REQ.
REQ-025 On AR handshake without redirect, fetch_pc <= fetch_pc + 4, modulo 2^ADDR_WIDTH (32'hFFFF_FFFC wraps to 0).
REQ-026 On rvalid in WAIT with drop=0, enqueue {req_pc, rdata, rresp!=0}; req_pc is the address latched at AR handshake.
REQ-027 out_valid = queue not empty; dequeue on out_valid&&out_ready; out_pc, out_inst and out_fault come from the head entry.
REQ-028 Simultaneous enqueue and dequeue at any occupancy, including full, keeps the count unchanged; overflow is impossible by REQ-022.
REQ-029 Redirect: queue flushed (count=0 next cycle), fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}; takes priority over a same-cycle enqueue or dequeue.
REQ-030 Redirect in REQ, or in WAIT without same-cycle rvalid: set drop=1; the pending AR still completes at its old address, and its response is discarded.
REQ-031 Redirect in WAIT with same-cycle rvalid: that response is discarded, and drop stays 0.
REQ-032 drop clears when the discarded response is consumed; the next request uses the redirected fetch_pc.
REQ-033 A fault entry does not stop fetching; sequential fetch continues.
REQ-034 Latency: with a zero-wait slave (arready=1 in REQ, rvalid one cycle after AR handshake), out_valid rises 1 cycle after rvalid; with out_ready=1, throughput is 1 instruction per 3 cycles.

Reset
REQ-035 Asynchronous on rst_n low: FSM=IDLE, fetch_pc=RESET_PC, drop=0, queue empty.
REQ-036 During reset: arvalid=0, rready=0, out_valid=0, out_pc=0, out_inst=0, out_fault=0.
REQ-037 Reset during REQ or WAIT abandons the transaction; no entry is enqueued after release.
REQ-038 First AR after release is at RESET_PC, no earlier than the first clock edge after release.

Structure
REQ-039 Package ifu_pkg holds the fetch FSM state encoding, the RESET_PC default and the queue entry field widths.
REQ-040 Queue is sub-module ifu_fifo: parametrised width/DEPTH, with flush, push, pop, count, empty and full outputs.

Verification
REQ-041 Reset release, zero-wait slave returning 32'h0000_0013, out_ready=1: AR addresses 80000000, 80000004, 80000008; out_pc follows the same sequence.
REQ-042 out_ready=0, DEPTH=4: exactly 4 entries queued, arvalid stays 0 afterward; one pop -> exactly one new AR.
REQ-043 Redirect to 32'h8000_0102 while in WAIT: in-flight data not output, queue empty, next araddr = 32'h8000_0100.
REQ-044 arready held low 5 cycles with a redirect in between: araddr stable, old response dropped, then fetch resumes at the redirect target.
REQ-045 rresp=2'b10 on the 2nd fetch: out_fault=1 for PC 80000004 only, and 80000008 is still fetched.
REQ-046 Redirect to 32'hFFFF_FFFC: the next two AR addresses are FFFF_FFFC and 0000_0000.
